// File: rtl/network_tx_stage.sv
// Queues data-plus-tag words from the output stage and sends each one as a
// frame of flits on a valid/ready link. Each frame ends with an XOR parity flit.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no frame in flight; the head word is loaded once one is queued
// SEND   | data flits go out LSB first from the shift register
// PARITY | the parity flit is presented with link_last_out high
module network_tx_stage #(
    parameter int data_size  = 32,
    parameter int tag_size   = 8,
    parameter int flit_width = 8,
    parameter int fifo_depth = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            network_data_ready_in,
    input  logic [data_size+tag_size-1:0]   ndt_in,
    input  logic                            link_ready_in,
    output logic                            link_valid_out,
    output logic [flit_width-1:0]           link_data_out,
    output logic                            link_last_out,
    output logic [$clog2(fifo_depth):0]     fifo_count_out,
    output logic                            overflow_out,
    output logic                            busy_out
);
    localparam int WORD_W    = data_size + tag_size;
    localparam int NUM_FLITS = WORD_W / flit_width;
    localparam int PTR_W     = $clog2(fifo_depth);
    localparam int CNT_W     = PTR_W + 1;
    localparam int IDX_W     = $clog2(NUM_FLITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FLITS - 1);
    localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(fifo_depth);

    typedef enum logic [1:0] {IDLE, SEND, PARITY} state_t;

    state_t                  state_q, state_d;
    logic [WORD_W-1:0]       shift_q, shift_d;
    logic [flit_width-1:0]   parity_q, parity_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WORD_W-1:0]       mem_q [fifo_depth];
    logic [WORD_W-1:0]       mem_d [fifo_depth];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    pop;
    logic                    push_ok;

    // Serializer next state; a pop happens whenever a word is loaded into the shift register.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        idx_d    = idx_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    shift_d  = mem_q[rd_ptr_q];
                    parity_d = '0;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (link_ready_in) begin
                    parity_d = parity_q ^ shift_q[flit_width-1:0];
                    shift_d  = shift_q >> flit_width;
                    idx_d    = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (link_ready_in) begin
                    if (count_q != '0) begin
                        // Chain straight into the next frame with no idle cycle.
                        pop      = 1'b1;
                        shift_d  = mem_q[rd_ptr_q];
                        parity_d = '0;
                        idx_d    = '0;
                        state_d  = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping; a push into a full FIFO still succeeds when a pop frees a slot on the same edge.
    always_comb begin
        mem_d      = mem_q;
        push_ok    = network_data_ready_in && ((count_q < DEPTH) || pop);
        overflow_d = overflow_q || (network_data_ready_in && !push_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = ndt_in;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end

    // State and storage registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            parity_q   <= '0;
            idx_q      <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            idx_q      <= idx_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Outputs decoded only from registered state, so a stall holds them steady.
    always_comb begin
        link_valid_out = (state_q != IDLE);
        busy_out       = (state_q != IDLE);
        link_last_out  = (state_q == PARITY);
        fifo_count_out = count_q;
        overflow_out   = overflow_q;
        case (state_q)
            SEND:    link_data_out = shift_q[flit_width-1:0];
            PARITY:  link_data_out = parity_q;
            default: link_data_out = '0;
        endcase
    end

endmodule
